// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_port_arbiter_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester picker: round-robin on a last-grant pointer, or port 1 fixed priority.
module rr_arb2
    import ram_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       mode,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last;

    // Reset to the data port so the fetch port wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last <= PORT_DATA;
        end else if (advance && (gnt != 2'b00)) begin
            last <= gnt[PORT_DATA];
        end
    end

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (mode || (last == PORT_IFETCH)) ? 2'b10 : 2'b01;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates a single-port synchronous-read RAM between fetch (port 0) and data (port 1).
// Define RAM_PORT_ARBITER_CLEAR_EN to zero the whole RAM after reset before serving requests.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int PRIO_MODE  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [31:0]           p0_req_wdata,
    output logic                  p0_rsp_valid,
    output logic [31:0]           p0_rsp_rdata,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_we,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [31:0]           p1_req_wdata,
    output logic                  p1_rsp_valid,
    output logic [31:0]           p1_rsp_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout,
    output logic                  busy
);

    state_t                  state;
    state_t                  state_next;
    logic                    run;
    logic [1:0]              gnt;
    logic                    rsp_vld_q;
    logic                    rsp_own_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             din_q;

`ifdef RAM_PORT_ARBITER_CLEAR_EN
    logic [ADDR_WIDTH-1:0]   clr_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
        end
    end

    assign busy = (state != ST_RUN);
`else
    assign busy = 1'b0;
`endif

    assign run = rst_n && (state == ST_RUN);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({p1_req_valid, p0_req_valid} & {2{run}}),
        .mode    (PRIO_MODE == PRIO_FIXED),
        .advance (run),
        .gnt     (gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
`ifdef RAM_PORT_ARBITER_CLEAR_EN
            state <= ST_CLEAR;
`else
            state <= ST_RUN;
`endif
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        p0_req_ready = gnt[PORT_IFETCH];
        p1_req_ready = gnt[PORT_DATA];
        ram_we       = 1'b0;
        ram_addr     = addr_q;
        ram_din      = din_q;
        case (state)
            ST_CLEAR: begin
`ifdef RAM_PORT_ARBITER_CLEAR_EN
                ram_we   = 1'b1;
                ram_addr = clr_cnt;
                ram_din  = '0;
                if (clr_cnt == '1) state_next = ST_RUN;
`else
                state_next = ST_RUN;
`endif
            end
            ST_RUN: begin
                if (gnt[PORT_DATA]) begin
                    ram_we   = p1_req_we;
                    ram_addr = p1_req_addr;
                    ram_din  = p1_req_wdata;
                end else if (gnt[PORT_IFETCH]) begin
                    ram_we   = p0_req_we;
                    ram_addr = p0_req_addr;
                    ram_din  = p0_req_wdata;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // addr_q/din_q track whatever was last presented, so idle cycles hold the bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_vld_q <= 1'b0;
            rsp_own_q <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
        end else begin
            rsp_vld_q <= |gnt;
            if (|gnt) rsp_own_q <= gnt[PORT_DATA];
            addr_q    <= ram_addr;
            din_q     <= ram_din;
        end
    end

    assign p0_rsp_valid = rsp_vld_q && (rsp_own_q == PORT_IFETCH);
    assign p1_rsp_valid = rsp_vld_q && (rsp_own_q == PORT_DATA);
    assign p0_rsp_rdata = p0_rsp_valid ? ram_dout : '0;
    assign p1_rsp_rdata = p1_rsp_valid ? ram_dout : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: instance 0 round-robin, instance 1 fixed priority, each with a RAM model.
module tb_ram_port_arbiter;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic v0[2], v1[2], we0[2], we1[2];
    logic [AW-1:0] a0[2], a1[2];
    logic [31:0] d0[2], d1[2];
    logic r0[2], r1[2], rv0[2], rv1[2];
    logic [31:0] rd0[2], rd1[2];
    logic rwe[2];
    logic [AW-1:0] raddr[2];
    logic [31:0] rdin[2], rdout[2];
    logic busy[2];

    logic [31:0] ram[2][DEPTH];
    logic pl_en;
    int unsigned pl_k;
    logic [AW-1:0] pl_addr;
    logic [31:0] pl_data;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_port_arbiter #(.ADDR_WIDTH(AW), .PRIO_MODE(g)) dut (
            .clk(clk), .rst_n(rst_n),
            .p0_req_valid(v0[g]), .p0_req_ready(r0[g]), .p0_req_we(we0[g]),
            .p0_req_addr(a0[g]), .p0_req_wdata(d0[g]),
            .p0_rsp_valid(rv0[g]), .p0_rsp_rdata(rd0[g]),
            .p1_req_valid(v1[g]), .p1_req_ready(r1[g]), .p1_req_we(we1[g]),
            .p1_req_addr(a1[g]), .p1_req_wdata(d1[g]),
            .p1_rsp_valid(rv1[g]), .p1_rsp_rdata(rd1[g]),
            .ram_we(rwe[g]), .ram_addr(raddr[g]), .ram_din(rdin[g]),
            .ram_dout(rdout[g]), .busy(busy[g])
        );
    end

    // Read-before-write synchronous RAM; the preload path lets the bench seed contents.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            rdout[k] <= ram[k][raddr[k]];
            if (pl_en && (pl_k == k)) ram[k][pl_addr] <= pl_data;
            else if (rwe[k]) ram[k][raddr[k]] <= rdin[k];
        end
    end

    int total = 0;
    int bad = 0;

    // Reference model: shadow memory, last-granted port, expected pending response.
    logic [31:0] ref_mem[2][DEPTH];
    logic m_last[2], m_rv0[2], m_rv1[2];
    logic [31:0] m_rd[2];
    logic [AW-1:0] m_hold[2];
    int m_clr[2];
    logic e_g0[2], e_g1[2], e_we[2], e_busy[2];
    logic [AW-1:0] e_addr[2];
    logic [31:0] e_din[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 1'b1;
            m_rv0[k]  = 1'b0;
            m_rv1[k]  = 1'b0;
            m_rd[k]   = '0;
            m_hold[k] = '0;
`ifdef RAM_PORT_ARBITER_CLEAR_EN
            m_clr[k]  = DEPTH;
`else
            m_clr[k]  = 0;
`endif
        end
    endtask

    task automatic model_eval();
        for (int k = 0; k < 2; k++) begin
            e_g0[k] = 1'b0;
            e_g1[k] = 1'b0;
            e_busy[k] = (m_clr[k] > 0);
            if (m_clr[k] > 0) begin
                e_we[k] = 1'b1;
                e_addr[k] = AW'(DEPTH - m_clr[k]);
                e_din[k] = '0;
            end else begin
                if (v0[k] && v1[k]) begin
                    if (k == 1 || m_last[k] == 1'b0) e_g1[k] = 1'b1;
                    else e_g0[k] = 1'b1;
                end else if (v0[k]) e_g0[k] = 1'b1;
                else if (v1[k]) e_g1[k] = 1'b1;
                e_we[k]   = e_g0[k] ? we0[k] : (e_g1[k] ? we1[k] : 1'b0);
                e_addr[k] = e_g0[k] ? a0[k] : (e_g1[k] ? a1[k] : m_hold[k]);
                e_din[k]  = e_g0[k] ? d0[k] : (e_g1[k] ? d1[k] : '0);
            end
        end
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_rv0[k] = e_g0[k];
                m_rv1[k] = e_g1[k];
                if (m_clr[k] > 0) begin
                    ref_mem[k][e_addr[k]] = '0;
                    m_hold[k] = e_addr[k];
                    m_clr[k]--;
                end else if (e_g0[k] || e_g1[k]) begin
                    m_rd[k] = ref_mem[k][e_addr[k]];
                    if (e_we[k]) ref_mem[k][e_addr[k]] = e_din[k];
                    m_hold[k] = e_addr[k];
                    m_last[k] = e_g1[k];
                end
            end
        end
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            v0[k] = 1'b0; v1[k] = 1'b0; we0[k] = 1'b0; we1[k] = 1'b0;
            a0[k] = '0; a1[k] = '0; d0[k] = '0; d1[k] = '0;
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic next_cycle();
        model_eval();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic preload(input int k, input logic [AW-1:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_k = k; pl_addr = a; pl_data = d;
        ref_mem[k][a] = d;
        next_cycle();
        pl_en = 1'b0;
    endtask

    task automatic preload_all();
        idle();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < DEPTH; a++) preload(k, AW'(a), $urandom);
    endtask

    task automatic wait_clear();
        int n = 0;
        settle();
        while (busy[0] && n < 40) begin
            next_cycle();
            settle();
            n++;
        end
        total++;
        if (busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL wait_clear: busy=%0b after %0d cycles, required 0", busy[0], n);
        end
    endtask

    task automatic test_reset();
        idle();
        pl_en = 1'b0;
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        settle();
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({r0[k], r1[k], rv0[k], rv1[k]} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_hs[%0d]: rdy/rsp=%b required 0000", k, {r0[k], r1[k], rv0[k], rv1[k]});
            end
            total++;
            if (raddr[k] !== '0 || rdin[k] !== '0 || rd0[k] !== '0 || rd1[k] !== '0) begin
                bad++;
                $display("FAIL reset_bus[%0d]: addr=%h din=%h rd0=%h rd1=%h required zeros",
                         k, raddr[k], rdin[k], rd0[k], rd1[k]);
            end
            total++;
            if (rwe[k] !== e_we[k] || busy[k] !== e_busy[k]) begin
                bad++;
                $display("FAIL reset_we_busy[%0d]: we=%b busy=%b required we=%b busy=%b",
                         k, rwe[k], busy[k], e_we[k], e_busy[k]);
            end
        end
`ifdef RAM_PORT_ARBITER_CLEAR_EN
        begin
            int n = 0;
            v0[0] = 1'b1; a0[0] = 4'd3;
            settle();
            while (busy[0] && n < 40) begin
                total++;
                if (r0[0] !== 1'b0 || rwe[0] !== 1'b1 || raddr[0] !== AW'(n) || rdin[0] !== '0) begin
                    bad++;
                    $display("FAIL clear_cycle%0d: rdy=%b we=%b addr=%h din=%h required 0 1 %h 0",
                             n, r0[0], rwe[0], raddr[0], rdin[0], AW'(n));
                end
                next_cycle();
                settle();
                n++;
            end
            total++;
            if (n != DEPTH) begin
                bad++;
                $display("FAIL clear_len: busy cycles=%0d required %0d", n, DEPTH);
            end
            idle();
            for (int i = 0; i <= DEPTH; i++) begin
                if (i < DEPTH) begin v0[0] = 1'b1; a0[0] = AW'(i); end
                else idle();
                settle();
                if (i > 0) begin
                    total++;
                    if (rv0[0] !== 1'b1 || rd0[0] !== 32'h0) begin
                        bad++;
                        $display("FAIL clear_read%0d: valid=%b rdata=%h required 1 00000000", i - 1, rv0[0], rd0[0]);
                    end
                end
                next_cycle();
            end
        end
`endif
        idle();
        settle();
    endtask

    task automatic test_single_read();
        preload(0, 4'd5, 32'hDEADBEEF);
        v0[0] = 1'b1; a0[0] = 4'd5; we0[0] = 1'b0;
        settle();
        total++;
        if (r0[0] !== 1'b1 || r1[0] !== 1'b0 || rwe[0] !== 1'b0 || raddr[0] !== 4'd5) begin
            bad++;
            $display("FAIL single_accept: rdy0=%b rdy1=%b we=%b addr=%h required 1 0 0 5", r0[0], r1[0], rwe[0], raddr[0]);
        end
        next_cycle();
        idle();
        settle();
        total++;
        if (rv0[0] !== 1'b1 || rd0[0] !== 32'hDEADBEEF || rv1[0] !== 1'b0) begin
            bad++;
            $display("FAIL single_rsp: v0=%b rd0=%h v1=%b required 1 deadbeef 0", rv0[0], rd0[0], rv1[0]);
        end
        total++;
        if (raddr[0] !== 4'd5 || rwe[0] !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: addr=%h we=%b required 5 0", raddr[0], rwe[0]);
        end
        next_cycle();
    endtask

    task automatic test_rr_alternate();
        logic prev;
        preload(0, 4'd1, 32'h11);
        preload(0, 4'd2, 32'h22);
        prev = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                v0[0] = 1'b1; a0[0] = 4'd1; v1[0] = 1'b1; a1[0] = 4'd2;
            end else idle();
            settle();
            if (i < 8) begin
                total++;
                if (r0[0] !== e_g0[0] || r1[0] !== e_g1[0] || (i > 0 && r0[0] === prev)) begin
                    bad++;
                    $display("FAIL rr_grant%0d: rdy0=%b rdy1=%b required %b %b", i, r0[0], r1[0], e_g0[0], e_g1[0]);
                end
                prev = r0[0];
            end
            if (i > 0) begin
                total++;
                if (rv0[0] !== m_rv0[0] || rv1[0] !== m_rv1[0] ||
                    (m_rv0[0] && rd0[0] !== 32'h11) || (m_rv1[0] && rd1[0] !== 32'h22)) begin
                    bad++;
                    $display("FAIL rr_rsp%0d: v0=%b rd0=%h v1=%b rd1=%h required v0=%b v1=%b (11/22)",
                             i, rv0[0], rd0[0], rv1[0], rd1[0], m_rv0[0], m_rv1[0]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_fixed_prio();
        for (int i = 0; i < 4; i++) begin
            v0[1] = 1'b1; a0[1] = 4'd3; v1[1] = 1'b1; a1[1] = 4'd4;
            settle();
            total++;
            if (r1[1] !== 1'b1 || r0[1] !== 1'b0 || raddr[1] !== 4'd4) begin
                bad++;
                $display("FAIL fixed_p1_%0d: rdy0=%b rdy1=%b addr=%h required 0 1 4", i, r0[1], r1[1], raddr[1]);
            end
            next_cycle();
        end
        v1[1] = 1'b0;
        settle();
        total++;
        if (r0[1] !== 1'b1 || r1[1] !== 1'b0 || raddr[1] !== 4'd3 || rv1[1] !== 1'b1 || rd1[1] !== ref_mem[1][4]) begin
            bad++;
            $display("FAIL fixed_p0: rdy0=%b rdy1=%b addr=%h v1=%b rd1=%h required 1 0 3 1 %h",
                     r0[1], r1[1], raddr[1], rv1[1], rd1[1], ref_mem[1][4]);
        end
        next_cycle();
        idle();
        settle();
        next_cycle();
    endtask

    task automatic test_write_then_read();
        preload(0, 4'd7, 32'h01234567);
        v1[0] = 1'b1; we1[0] = 1'b1; a1[0] = 4'd7; d1[0] = 32'hCAFEF00D;
        settle();
        total++;
        if (r1[0] !== 1'b1 || rwe[0] !== 1'b1 || raddr[0] !== 4'd7 || rdin[0] !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL wr_issue: rdy1=%b we=%b addr=%h din=%h required 1 1 7 cafef00d", r1[0], rwe[0], raddr[0], rdin[0]);
        end
        next_cycle();
        idle();
        v0[0] = 1'b1; a0[0] = 4'd7;
        settle();
        total++;
        if (rv1[0] !== 1'b1 || rd1[0] !== 32'h01234567 || r0[0] !== 1'b1 || rwe[0] !== 1'b0) begin
            bad++;
            $display("FAIL wr_ack: v1=%b rd1=%h rdy0=%b we=%b required 1 01234567 1 0", rv1[0], rd1[0], r0[0], rwe[0]);
        end
        next_cycle();
        idle();
        settle();
        total++;
        if (rv0[0] !== 1'b1 || rd0[0] !== 32'hCAFEF00D || rv1[0] !== 1'b0) begin
            bad++;
            $display("FAIL rd_after_wr: v0=%b rd0=%h v1=%b required 1 cafef00d 0", rv0[0], rd0[0], rv1[0]);
        end
        next_cycle();
    endtask

    task automatic test_reset_inflight();
        v0[0] = 1'b1; a0[0] = 4'd5;
        settle();
        next_cycle();
        idle();
        rst_n = 1'b0;
        settle();
        total++;
        if (rv0[0] !== 1'b1) begin
            bad++;
            $display("FAIL inflight_pre: v0=%b required 1", rv0[0]);
        end
        next_cycle();
        rst_n = 1'b1;
        settle();
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({rv0[k], rv1[k], r0[k], r1[k]} !== 4'b0000 || raddr[k] !== '0 || rdin[k] !== '0 ||
                rd0[k] !== '0 || rd1[k] !== '0 || rwe[k] !== e_we[k] || busy[k] !== e_busy[k]) begin
                bad++;
                $display("FAIL inflight_drop[%0d]: v=%b%b rdy=%b%b addr=%h din=%h we=%b busy=%b required zeros we=%b busy=%b",
                         k, rv0[k], rv1[k], r0[k], r1[k], raddr[k], rdin[k], rwe[k], busy[k], e_we[k], e_busy[k]);
            end
        end
`ifdef RAM_PORT_ARBITER_CLEAR_EN
        wait_clear();
        preload_all();
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!(v0[k] && !e_g0[k])) begin
                    v0[k] = ($urandom_range(0, 3) != 0); we0[k] = ($urandom_range(0, 7) == 0);
                    a0[k] = AW'($urandom); d0[k] = $urandom;
                end
                if (!(v1[k] && !e_g1[k])) begin
                    v1[k] = ($urandom_range(0, 3) != 0); we1[k] = ($urandom_range(0, 2) == 0);
                    a1[k] = AW'($urandom); d1[k] = $urandom;
                end
            end
            settle();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (r0[k] !== e_g0[k] || r1[k] !== e_g1[k] || rwe[k] !== e_we[k] || raddr[k] !== e_addr[k] ||
                    ((e_g0[k] || e_g1[k]) && rdin[k] !== e_din[k])) begin
                    bad++;
                    $display("FAIL rand_req[%0d] cyc%0d: rdy=%b%b we=%b addr=%h din=%h required %b%b %b %h %h",
                             k, i, r0[k], r1[k], rwe[k], raddr[k], rdin[k], e_g0[k], e_g1[k], e_we[k], e_addr[k], e_din[k]);
                end
                total++;
                if (rv0[k] !== m_rv0[k] || rv1[k] !== m_rv1[k] ||
                    (m_rv0[k] && rd0[k] !== m_rd[k]) || (m_rv1[k] && rd1[k] !== m_rd[k])) begin
                    bad++;
                    $display("FAIL rand_rsp[%0d] cyc%0d: v=%b%b rd0=%h rd1=%h required v=%b%b data=%h",
                             k, i, rv0[k], rv1[k], rd0[k], rd1[k], m_rv0[k], m_rv1[k], m_rd[k]);
                end
            end
            next_cycle();
        end
        idle();
        settle();
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        pl_en = 1'b0;
        pl_k = 0; pl_addr = '0; pl_data = '0;
        idle();
        model_reset();
        @(negedge clk);
        test_reset();
        preload_all();
        test_single_read();
        test_rr_alternate();
        test_fixed_prio();
        test_write_then_read();
        test_reset_inflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares one single-port, synchronous-read 32-bit RAM between two requesters:
- port 0: instruction fetch, read-only in practice;
- port 1: data load/store.
Sits between the core's fetch/LSU and the RAM instance. Handles per-cycle arbitration, write gating and response routing, and exposes a valid/ready request handshake plus a fixed-latency response per port. One transaction per cycle is sustained with no bubbles.

Parameters:
- ADDR_WIDTH, 10, word address width; must match the RAM instance.
- PRIO_MODE, 0; 0 = round-robin between ports, 1 = port 1 fixed priority.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- p0_req_valid  in  1  port 0 request valid.
- p0_req_ready  out  1  port 0 request accepted this cycle.
- p0_req_we  in  1  port 0 write enable.
- p0_req_addr  in  ADDR_WIDTH  port 0 word address.
- p0_req_wdata  in  32  port 0 write data.
- p0_rsp_valid  out  1  port 0 response valid.
- p0_rsp_rdata  out  32  port 0 read data.
- p1_*  same set as p0_*, for port 1.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data, registered inside the RAM, 1-cycle latency.
- busy  out  1  high while not in RUN state.

Behaviour:
- States: CLEAR (only when the optional feature is compiled in) and RUN.
  - Reset enters CLEAR if the feature is enabled, otherwise RUN.
  - CLEAR moves to RUN after the last clear write.
- Reset values (rst_n=0 sampled):
  - p0/p1_req_ready = 0, p0/p1_rsp_valid = 0, ram_we = 0.
  - ram_addr = 0, ram_din = 0, rsp_rdata = 0.
  - Round-robin last-grant pointer = 1, so port 0 wins the first tie.
  - busy follows state.
- Reset mid-operation: any in-flight response is dropped; rsp_valid is 0 in the cycle after reset is sampled.
- Arbitration in RUN is combinational from the current req_valid values:
  - One valid request: it is granted.
  - Both valid, PRIO_MODE=0: grant the port that was not last granted; the pointer updates only on an actual grant.
  - Both valid, PRIO_MODE=1: port 1 always wins, and port 0 stalls while port 1 is valid.
- Grant handshake:
  - For the granted port, req_ready=1 and ram_we/ram_addr/ram_din are driven from that port in the same cycle.
  - The loser has req_ready=0 and must hold its request stable.
  - With no grant, ram_we=0 and ram_addr holds its last value.
- Response:
  - rsp_valid pulses on the granted port exactly 1 cycle after acceptance.
  - rsp_rdata = ram_dout.
  - Responses are returned in order, with no response backpressure.
  - Writes also produce rsp_valid as an ack; rsp_rdata is then the pre-write contents (RAM read-before-write).
- Response routing: a 1-bit owner register plus a valid register are captured at grant; their reset value is 0.
- Back-to-back accepts on alternating ports each return rsp on the correct port.
- Address wrap: ADDR_WIDTH-bit addresses, no bounds checking.
- req_ready is 0 in every state other than RUN.

Optional Feature:
- Macro: RAM_PORT_ARBITER_CLEAR_EN.
- Enabled:
  - After reset, the CLEAR state writes 0 to every address, 0 to 2^ADDR_WIDTH-1, one per cycle, using a counter.
  - busy=1 and both req_ready=0 throughout, then the block enters RUN.
  - This overrides the RAM's $readmemh init image; use only for data RAMs.
- Disabled:
  - RUN starts the first cycle after reset; busy is tied 0.
  - No counter logic is present.

Decomposition:
- Package ram_port_arbiter_pkg:
  - state enum {ST_CLEAR, ST_RUN};
  - port index constants PORT_IFETCH=0, PORT_DATA=1;
  - PRIO_RR=0, PRIO_FIXED=1.
- Sub-module rr_arb2: a 2-requester round-robin/fixed picker holding the last-grant pointer.
  - Inputs: req[1:0], mode, advance.
  - Output: one-hot gnt[1:0].

Test Plan:
- Preload RAM addr 5 = 0xDEADBEEF; p0 read addr 5 at cycle T -> p0_req_ready=1 at T; p0_rsp_valid=1, rdata=0xDEADBEEF at T+1; p1_rsp_valid stays 0.
- PRIO_MODE=0, both ports read continuously (p0 addr 1, p1 addr 2, contents 0x11/0x22) -> grants alternate p0,p1,p0,... and responses return 0x11 on p0, 0x22 on p1, with no idle RAM cycle.
- PRIO_MODE=1, both ports valid for 4 cycles -> p1 is granted all 4 cycles and p0_req_ready=0; p0 is granted on the cycle p1 drops valid.
- p1 writes 0xCAFEF00D to addr 7, then p0 reads addr 7 the next cycle -> p1 ack rdata = old value; p0 rdata = 0xCAFEF00D.
- Assert rst_n=0 for 1 cycle while a read is in flight -> no rsp_valid on either port the following cycle; all outputs at reset values.
- With RAM_PORT_ARBITER_CLEAR_EN, ADDR_WIDTH=4 -> busy=1 and req_ready=0 for 16 cycles after reset; subsequent reads of addrs 0..15 return 0.
